idwt_1: RTL and testbench

- Single-level inverse LeGall 5/3 integer lifting wavelet transform (synthesis). It is the decoder counterpart of the forward dwt blocks.
- Consumes a frame of NUMEL coefficients, interleaved as s0,d0,s1,d1,… (approximation, detail), and emits NUMEL reconstructed signed samples x0…x(NUMEL-1) in natural order.
- Same streaming valid-only interface as the forward chain. Used to close the loop for bit-exact reconstruction checks against the raw data set.

---
 rtl/dwt_pkg.sv | 33 +++
 rtl/idwt53_lift.sv | 60 ++++++
 rtl/idwt_1.sv | 171 +++++++++++++++++
 tb/tb_idwt_1.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// -----------------------------------------------------------------------------
// dwt_pkg
// Shared definitions for the LeGall 5/3 lifting blocks (forward and inverse).
//   DWT_WIDTH   : default signed sample/coefficient width
//   PRED_SHIFT  : predict step divisor as a right shift (floor /2)
//   UPD_OFFSET  : update step rounding offset (+2 before /4)
//   UPD_SHIFT   : update step divisor as a right shift (floor /4)
//   phase_e     : which half of a coefficient pair is expected next
//   floor_shr() : arithmetic right shift, i.e. division rounding toward -inf
// -----------------------------------------------------------------------------
package dwt_pkg;

  localparam int DWT_WIDTH  = 16;
  localparam int PRED_SHIFT = 1;
  localparam int UPD_OFFSET = 2;
  localparam int UPD_SHIFT  = 2;

  // Even frame index carries s(n), odd frame index carries d(n).
  typedef enum logic {
    EXP_S = 1'b0,
    EXP_D = 1'b1
  } phase_e;

  // Operates on a wide signed container so any block width fits; callers
  // sign-extend into it and cast the result back to their own sum width.
  function automatic logic signed [63:0] floor_shr(
    input logic signed [63:0] v,
    input int unsigned        sh
  );
    return v >>> sh;
  endfunction

endpackage

// File: rtl/idwt53_lift.sv
// -----------------------------------------------------------------------------
// idwt53_lift
// Combinational inverse 5/3 lifting kernel for one coefficient pair.
//   i_s          : s(n)
//   i_d          : d(n)
//   i_d_prev     : d(n-1) (ignored when i_first)
//   i_x_prev     : x(2n-2) (only meaningful when not i_first)
//   i_first      : n == 0, selects symmetric extension d(-1) := d(0)
//   o_x_even     : x(2n)   = s(n) - floor((d(n-1)+d(n)+2)/4)
//   o_x_odd_prev : x(2n-1) = d(n-1) + floor((x(2n-2)+x(2n))/2)
// All sums are formed in WIDTH+2 bits and truncated back to WIDTH.
// -----------------------------------------------------------------------------
module idwt53_lift
  import dwt_pkg::*;
#(
  parameter int WIDTH = DWT_WIDTH
) (
  input  logic signed [WIDTH-1:0] i_s,
  input  logic signed [WIDTH-1:0] i_d,
  input  logic signed [WIDTH-1:0] i_d_prev,
  input  logic signed [WIDTH-1:0] i_x_prev,
  input  logic                    i_first,
  output logic signed [WIDTH-1:0] o_x_even,
  output logic signed [WIDTH-1:0] o_x_odd_prev
);

  localparam int SW = WIDTH + 2;

  logic signed [SW-1:0]    w_s_ext;
  logic signed [SW-1:0]    w_d_ext;
  logic signed [SW-1:0]    w_dp_ext;
  logic signed [SW-1:0]    w_xp_ext;
  logic signed [SW-1:0]    w_xe_ext;
  logic signed [SW-1:0]    w_upd_sum;
  logic signed [SW-1:0]    w_upd_q;
  logic signed [SW-1:0]    w_pred_sum;
  logic signed [SW-1:0]    w_pred_q;
  logic signed [WIDTH-1:0] w_x_even;

  assign w_s_ext  = SW'(i_s);
  assign w_d_ext  = SW'(i_d);
  // Left boundary: mirror d(0) into the missing d(-1).
  assign w_dp_ext = i_first ? SW'(i_d) : SW'(i_d_prev);
  assign w_xp_ext = SW'(i_x_prev);

  // Update step (undo): x(2n) = s(n) - floor((d(n-1) + d(n) + 2) / 4)
  assign w_upd_sum = w_dp_ext + w_d_ext + SW'(UPD_OFFSET);
  assign w_upd_q   = SW'(floor_shr(64'(w_upd_sum), UPD_SHIFT));
  assign w_x_even  = WIDTH'(w_s_ext - w_upd_q);

  // Predict step (undo) uses the truncated x(2n), identical to what gets
  // stored as x_prev for the next pair.
  assign w_xe_ext   = SW'(w_x_even);
  assign w_pred_sum = w_xp_ext + w_xe_ext;
  assign w_pred_q   = SW'(floor_shr(64'(w_pred_sum), PRED_SHIFT));

  assign o_x_even     = w_x_even;
  assign o_x_odd_prev = WIDTH'(SW'(i_d_prev) + w_pred_q);

endmodule

// File: rtl/idwt_1.sv
// -----------------------------------------------------------------------------
// idwt_1
// Single-level inverse LeGall 5/3 integer lifting transform (streaming).
// Takes a frame of NUMEL interleaved coefficients s0,d0,s1,d1,... and emits
// NUMEL reconstructed samples x0..x(NUMEL-1) in natural order, 3 cycles of
// latency per sample under contiguous input.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   valid_i : din carries a coefficient this cycle
//   din     : signed coefficient (even index s(n), odd index d(n))
//   valid_o : dout carries a reconstructed sample this cycle
//   dout    : signed reconstructed sample (holds while valid_o is low)
//   last_o  : marks x(NUMEL-1)
// -----------------------------------------------------------------------------
module idwt_1
  import dwt_pkg::*;
#(
  parameter int WIDTH = DWT_WIDTH,
  parameter int NUMEL = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] din,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] dout,
  output logic                    last_o
);

  localparam int IDX_W = (NUMEL > 2) ? $clog2(NUMEL) : 1;
  localparam int SW    = WIDTH + 2;

  // Frame position and lifting history
  logic [IDX_W-1:0]        r_idx;
  logic signed [WIDTH-1:0] r_s;
  logic signed [WIDTH-1:0] r_d_prev;
  logic signed [WIDTH-1:0] r_x_prev;

  // Emit shift register. Slot 0 is what is on the output this cycle; slot 1
  // and slot 2 are due one and two cycles later. r_dout carries slot 0's
  // sample so that it can hold its value while nothing is emitted.
  logic                    r_vld0, r_vld1, r_vld2;
  logic                    r_last0, r_last1, r_last2;
  logic signed [WIDTH-1:0] r_dout;
  logic signed [WIDTH-1:0] r_x1, r_x2;

  phase_e                  w_phase;
  logic                    w_idx_wrap;
  logic                    w_s_acc;
  logic                    w_d_acc;
  logic                    w_first;
  logic                    w_last_pair;
  logic signed [WIDTH-1:0] w_x_even;
  logic signed [WIDTH-1:0] w_x_odd_prev;
  logic signed [WIDTH-1:0] w_x_last;

  logic                    w_nx_vld0, w_nx_vld1, w_nx_vld2;
  logic                    w_nx_last0, w_nx_last1, w_nx_last2;
  logic signed [WIDTH-1:0] w_nx_x0, w_nx_x1, w_nx_x2;

  assign w_phase     = phase_e'(r_idx[0]);
  assign w_idx_wrap  = (r_idx == IDX_W'(NUMEL - 1));
  assign w_s_acc     = valid_i && (w_phase == EXP_S);
  assign w_d_acc     = valid_i && (w_phase == EXP_D);
  assign w_first     = (r_idx == IDX_W'(1));
  assign w_last_pair = w_idx_wrap;

  idwt53_lift #(
    .WIDTH (WIDTH)
  ) u_lift (
    .i_s          (r_s),
    .i_d          (din),
    .i_d_prev     (r_d_prev),
    .i_x_prev     (r_x_prev),
    .i_first      (w_first),
    .o_x_even     (w_x_even),
    .o_x_odd_prev (w_x_odd_prev)
  );

  // Right boundary: mirrored x(NUMEL) equals x(NUMEL-2), so the predict
  // average collapses to x(NUMEL-2) itself.
  assign w_x_last = WIDTH'(SW'(din) + SW'(w_x_even));

  // Index counter: advances only on accepted coefficients, wraps per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
    end else if (valid_i) begin
      r_idx <= w_idx_wrap ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Lifting history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s      <= '0;
      r_d_prev <= '0;
      r_x_prev <= '0;
    end else begin
      if (w_s_acc) begin
        r_s <= din;
      end
      if (w_d_acc) begin
        r_d_prev <= din;
        r_x_prev <= w_x_even;
      end
    end
  end

  // Emit schedule. Default is a plain shift toward slot 0. A d-accept loads
  // x(2n-1) into slot 0, x(2n) into slot 1 and, at the end of a frame,
  // x(NUMEL-1) into slot 2. For n == 0 slot 0 instead keeps the shifted
  // entry, which is the previous frame's tail sample when frames run
  // back to back. For n > 0 the shifted entry is always empty because the
  // previous d-accept was at least two cycles earlier and was not a frame end.
  always_comb begin
    w_nx_vld0  = r_vld1;
    w_nx_last0 = r_last1;
    w_nx_x0    = r_x1;
    w_nx_vld1  = r_vld2;
    w_nx_last1 = r_last2;
    w_nx_x1    = r_x2;
    w_nx_vld2  = 1'b0;
    w_nx_last2 = 1'b0;
    w_nx_x2    = r_x2;
    if (w_d_acc) begin
      if (!w_first) begin
        w_nx_vld0  = 1'b1;
        w_nx_last0 = 1'b0;
        w_nx_x0    = w_x_odd_prev;
      end
      w_nx_vld1  = 1'b1;
      w_nx_last1 = 1'b0;
      w_nx_x1    = w_x_even;
      w_nx_vld2  = w_last_pair;
      w_nx_last2 = w_last_pair;
      w_nx_x2    = w_x_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_vld2  <= 1'b0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_last2 <= 1'b0;
      r_dout  <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
    end else begin
      r_vld0  <= w_nx_vld0;
      r_vld1  <= w_nx_vld1;
      r_vld2  <= w_nx_vld2;
      r_last0 <= w_nx_vld0 && w_nx_last0;
      r_last1 <= w_nx_last1;
      r_last2 <= w_nx_last2;
      r_x1    <= w_nx_x1;
      r_x2    <= w_nx_x2;
      if (w_nx_vld0) begin
        r_dout <= w_nx_x0;
      end
    end
  end

  assign valid_o = r_vld0;
  assign last_o  = r_last0;
  assign dout    = r_dout;

endmodule

// File: tb/tb_idwt_1.sv
// -----------------------------------------------------------------------------
// tb_idwt_1
// Directed test of idwt_1 with NUMEL=8, WIDTH=16. The driver pushes each
// expected sample (value, last flag, output cycle) when it issues the d(n)
// that produces it; a separate monitor pops and compares on every valid_o.
// -----------------------------------------------------------------------------
module tb_idwt_1;

  localparam int W = 16;
  localparam int N = 8;

  logic                clk;
  logic                rst;
  logic                valid_i;
  logic signed [W-1:0] din;
  logic                valid_o;
  logic signed [W-1:0] dout;
  logic                last_o;

  typedef struct {
    logic signed [W-1:0] x;
    logic                last;
    int                  cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  int ramp_in[N]  = '{10, 0, 20, 0, 30, 0, 40, 0};
  int ramp_out[N] = '{10, 15, 20, 25, 30, 35, 40, 40};
  int rnd_in[N]   = '{0, 4, 0, 0, 0, 0, 0, 0};
  int rnd_out[N]  = '{-2, 2, -1, -1, 0, 0, 0, 0};

  idwt_1 #(
    .WIDTH (W),
    .NUMEL (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .din     (din),
    .valid_o (valid_o),
    .dout    (dout),
    .last_o  (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    // Anything due before now was never emitted.
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_output got none at cyc=%0d required x=%0d last=%0b at cyc=%0d",
               cyc, e.x, e.last, e.cyc);
    end
    if (valid_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_output got x=%0d last=%0b at cyc=%0d required no output",
                 dout, last_o, cyc);
      end else begin
        e = sb_q.pop_front();
        if (dout !== e.x || last_o !== e.last || cyc != e.cyc) begin
          errors++;
          $display("FAIL output got x=%0d last=%0b cyc=%0d required x=%0d last=%0b cyc=%0d",
                   dout, last_o, cyc, e.x, e.last, e.cyc);
        end else begin
          $display("out x=%0d last=%0b cyc=%0d ok", dout, last_o, cyc);
        end
      end
    end else if (last_o !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL stray_last got last_o=%0b with valid_o=0 required 0 at cyc=%0d",
               last_o, cyc);
    end
  end

  function automatic void push_exp(input int x, input logic last, input int c);
    exp_t e;
    e.x    = W'(x);
    e.last = last;
    e.cyc  = c;
    sb_q.push_back(e);
  endfunction

  // Drive the first `count` coefficients of a frame, idling `gap` cycles after
  // each. On every d(n) the expected emissions are queued: with the accept
  // edge numbered e, x(2n-1) is visible at cycle e, x(2n) at e+1 and x(7)
  // at e+2.
  task automatic send_frame(input int vin[N], input int vout[N], input int gap,
                            input int count);
    int e;
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      din     = W'(vin[i]);
      e       = cyc + 1;
      if (i % 2 == 1) begin
        if (i > 1) push_exp(vout[i-2], 1'b0, e);
        push_exp(vout[i-1], 1'b0, e + 1);
        if (i == N - 1) push_exp(vout[i], 1'b1, e + 2);
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        valid_i = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (valid_o !== 1'b0 || dout !== '0 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL %s got valid_o=%0b dout=%0d last_o=%0b required 0 0 0",
               tag, valid_o, dout, last_o);
    end else begin
      $display("%s valid_o=0 dout=0 last_o=0 ok", tag);
    end
  endtask

  initial begin
    rst     = 1'b0;
    valid_i = 1'b0;
    din     = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    rst = 1'b1;
    idle(2);

    // Ramp, contiguous
    send_frame(ramp_in, ramp_out, 0, N);
    idle(6);

    // Negative rounding
    send_frame(rnd_in, rnd_out, 0, N);
    idle(6);

    // Back-to-back frames
    send_frame(ramp_in, ramp_out, 0, N);
    send_frame(rnd_in, rnd_out, 0, N);
    idle(6);

    // Gapped ramp
    send_frame(ramp_in, ramp_out, 2, N);
    idle(6);

    // Reset mid-frame after 10,0,20. x0 is legitimately visible on the
    // cycle reset is asserted; reset is applied just after the monitor has
    // sampled it, then the rest of that frame is discarded.
    send_frame(ramp_in, ramp_out, 0, 3);
    @(negedge clk);
    #2;
    rst     = 1'b0;
    valid_i = 1'b0;
    sb_q.delete();
    #1;
    check_reset_state("mid_reset");
    idle(2);
    rst = 1'b1;
    send_frame(ramp_in, ramp_out, 0, N);
    idle(6);

    // Drain, bounded
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending outputs required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
